// File: rtl/spi_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bus_arb
//  Purpose  : Two-requester arbiter in front of one shared 16-bit SPI master.
//             Requests are latched per requester, served alternately on a
//             tie, and separated by a fixed idle gap. A stalled transaction
//             is aborted after a WAIT-state timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_bus_arb #(
    parameter int GAP_CYC = 4,     // idle cycles between transactions (>= 1)
    parameter int TMO_CYC = 1024   // WAIT cycles before abort (>= 2)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt0,
    input  logic [15:0] cmd0,
    input  logic        wrt1,
    input  logic [15:0] cmd1,
    output logic        busy0,
    output logic        busy1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data0,
    output logic [15:0] rd_data1,
    output logic        tmo0,
    output logic        tmo1,
    output logic        ovr0,
    output logic        ovr1,
    output logic        m_wrt,
    output logic [15:0] m_cmd,
    input  logic        m_done,
    input  logic [15:0] m_rd_data
);

    localparam int TCW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_pend0, r_pend1;
    logic [15:0]      r_cmd0, r_cmd1;
    logic             r_ovr0, r_ovr1;
    logic             r_gnt;        // requester currently in service
    logic             r_last_gnt;   // requester granted most recently
    logic [TCW-1:0]   r_tcnt;
    logic [GCW-1:0]   r_gcnt;
    logic             r_m_wrt;
    logic [15:0]      r_m_cmd;
    logic             r_done0, r_done1;
    logic             r_tmo0, r_tmo1;
    logic [15:0]      r_rd0, r_rd1;

    logic             w_grant;
    logic             w_gnt_sel;
    logic             w_complete;
    logic             w_timeout;
    logic             w_clr0, w_clr1;

    // Next-state and grant decision; a completion on the terminal count wins
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_sel   = r_gnt;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend0 || r_pend1) begin
                    w_grant     = 1'b1;
                    w_gnt_sel   = (r_pend0 && r_pend1) ? ~r_last_gnt : r_pend1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_GAP;
                end else if (r_tcnt == TCW'(TMO_CYC - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gcnt == GCW'(GAP_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_clr0 = (w_complete || w_timeout) && (r_gnt == 1'b0);
    assign w_clr1 = (w_complete || w_timeout) && (r_gnt == 1'b1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture: accept only when idle for that requester, else flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
            r_cmd0  <= 16'h0000;
            r_cmd1  <= 16'h0000;
            r_ovr0  <= 1'b0;
            r_ovr1  <= 1'b0;
        end else begin
            r_ovr0 <= wrt0 & r_pend0;
            r_ovr1 <= wrt1 & r_pend1;
            if (wrt0 && !r_pend0) begin
                r_pend0 <= 1'b1;
                r_cmd0  <= cmd0;
            end else if (w_clr0) begin
                r_pend0 <= 1'b0;
            end
            if (wrt1 && !r_pend1) begin
                r_pend1 <= 1'b1;
                r_cmd1  <= cmd1;
            end else if (w_clr1) begin
                r_pend1 <= 1'b0;
            end
        end
    end

    // Master launch, cycle counters and per-requester completion reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_wrt    <= 1'b0;
            r_m_cmd    <= 16'h0000;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_tcnt     <= '0;
            r_gcnt     <= '0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_tmo0     <= 1'b0;
            r_tmo1     <= 1'b0;
            r_rd0      <= 16'h0000;
            r_rd1      <= 16'h0000;
        end else begin
            r_m_wrt <= w_grant;
            if (w_grant) begin
                r_m_cmd    <= w_gnt_sel ? r_cmd1 : r_cmd0;
                r_gnt      <= w_gnt_sel;
                r_last_gnt <= w_gnt_sel;
            end
            r_tcnt  <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_tcnt + TCW'(1) : '0;
            r_gcnt  <= (r_state == S_GAP  && w_state_nxt == S_GAP)  ? r_gcnt + GCW'(1) : '0;
            r_done0 <= w_complete && (r_gnt == 1'b0);
            r_done1 <= w_complete && (r_gnt == 1'b1);
            r_tmo0  <= w_timeout  && (r_gnt == 1'b0);
            r_tmo1  <= w_timeout  && (r_gnt == 1'b1);
            if (w_complete && (r_gnt == 1'b0)) begin
                r_rd0 <= m_rd_data;
            end
            if (w_complete && (r_gnt == 1'b1)) begin
                r_rd1 <= m_rd_data;
            end
        end
    end

    assign busy0    = r_pend0;
    assign busy1    = r_pend1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign tmo0     = r_tmo0;
    assign tmo1     = r_tmo1;
    assign ovr0     = r_ovr0;
    assign ovr1     = r_ovr1;
    assign rd_data0 = r_rd0;
    assign rd_data1 = r_rd1;
    assign m_wrt    = r_m_wrt;
    assign m_cmd    = r_m_cmd;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_bus_arb
//  Purpose  : Directed scoreboard bench for spi_bus_arb with a simple
//             SPI master responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arb;

    localparam int GAP_CYC = 4;
    localparam int TMO_CYC = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrt0, wrt1;
    logic [15:0] cmd0, cmd1;
    logic        busy0, busy1, done0, done1, tmo0, tmo1, ovr0, ovr1;
    logic [15:0] rd_data0, rd_data1;
    logic        m_wrt;
    logic [15:0] m_cmd;
    logic        m_done;
    logic [15:0] m_rd_data;

    spi_bus_arb #(.GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .wrt0(wrt0), .cmd0(cmd0), .wrt1(wrt1), .cmd1(cmd1),
        .busy0(busy0), .busy1(busy1), .done0(done0), .done1(done1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .tmo0(tmo0), .tmo1(tmo1), .ovr0(ovr0), .ovr1(ovr1),
        .m_wrt(m_wrt), .m_cmd(m_cmd), .m_done(m_done), .m_rd_data(m_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues of expected responses
    logic [15:0] q_mwrt[$];
    logic [15:0] q_done0[$];
    logic [15:0] q_done1[$];
    logic [15:0] q_tmo0[$];
    logic [15:0] q_tmo1[$];
    logic        q_ovr0[$];
    logic        q_ovr1[$];

    int t_mwrt = 0;
    int n_mwrt = 0;
    int n_done1 = 0;

    // Master responder controls
    bit mst_en  = 1'b1;
    int mst_lat = 3;
    int stray_req = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [15:0] c);
        if (r == 0) begin wrt0 = 1'b1; cmd0 = c; end
        else        begin wrt1 = 1'b1; cmd1 = c; end
        tick(1);
        wrt0 = 1'b0;
        wrt1 = 1'b0;
    endtask

    // sel: 0=done0 1=done1 2=tmo0; returns the cycle in which it was seen
    task automatic wait_sig(input int sel, input int bound, input string nm, output int t);
        bit hit;
        hit = 1'b0;
        t   = -1;
        for (int i = 0; i < bound && !hit; i++) begin
            tick(1);
            case (sel)
                0:       hit = done0;
                1:       hit = done1;
                2:       hit = tmo0;
                default: hit = 1'b0;
            endcase
            if (hit) t = cyc;
        end
        chk({nm, " seen"}, hit, 1);
    endtask

    function automatic logic [15:0] resp(input logic [15:0] c);
        return (c == 16'hA400) ? 16'h00C3 : ~c;
    endfunction

    // SPI master model: answers mst_lat cycles after the m_wrt cycle
    initial begin
        int cnt;
        int stray_done;
        logic [15:0] dat;
        cnt = 0;
        stray_done = 0;
        dat = 16'h0000;
        m_done = 1'b0;
        m_rd_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            m_done = 1'b0;
            if (m_wrt && mst_en) begin
                cnt = mst_lat;
                dat = resp(m_cmd);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    m_done = 1'b1;
                    m_rd_data = dat;
                end
            end else if (stray_req != stray_done) begin
                stray_done++;
                m_done = 1'b1;
                m_rd_data = 16'hDEAD;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents an event
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_wrt) begin
                    n_mwrt++;
                    t_mwrt = cyc;
                    chk("m_wrt expected", q_mwrt.size() != 0, 1);
                    if (q_mwrt.size() != 0) chk("m_cmd", m_cmd, q_mwrt.pop_front());
                end
                if (done0) begin
                    chk("done0 expected", q_done0.size() != 0, 1);
                    if (q_done0.size() != 0) chk("rd_data0 at done0", rd_data0, q_done0.pop_front());
                end
                if (done1) begin
                    n_done1++;
                    chk("done1 expected", q_done1.size() != 0, 1);
                    if (q_done1.size() != 0) chk("rd_data1 at done1", rd_data1, q_done1.pop_front());
                end
                if (tmo0) begin
                    chk("tmo0 expected", q_tmo0.size() != 0, 1);
                    if (q_tmo0.size() != 0) chk("rd_data0 at tmo0", rd_data0, q_tmo0.pop_front());
                end
                if (tmo1) begin
                    chk("tmo1 expected", q_tmo1.size() != 0, 1);
                    if (q_tmo1.size() != 0) chk("rd_data1 at tmo1", rd_data1, q_tmo1.pop_front());
                end
                if (ovr0) begin
                    chk("ovr0 expected", q_ovr0.size() != 0, 1);
                    if (q_ovr0.size() != 0) void'(q_ovr0.pop_front());
                end
                if (ovr1) begin
                    chk("ovr1 expected", q_ovr1.size() != 0, 1);
                    if (q_ovr1.size() != 0) void'(q_ovr1.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int t_iss, t_a, t_b, n_before;
        rst_n = 1'b0;
        wrt0 = 1'b0; wrt1 = 1'b0; cmd0 = 16'h0; cmd1 = 16'h0;

        // Reset state
        tick(3);
        chk("reset outputs", {busy0, busy1, done0, done1, tmo0, tmo1, ovr0, ovr1,
                              m_wrt, m_cmd, rd_data0, rd_data1}, 64'h0);
        rst_n = 1'b1;
        tick(6);
        chk("no m_wrt after reset", n_mwrt, 0);

        // Simultaneous requests: requester 0 wins the first tie
        mst_lat = 3;
        q_mwrt.push_back(16'h1111); q_mwrt.push_back(16'h2222);
        q_done0.push_back(16'hEEEE); q_done1.push_back(16'hDDDD);
        wrt0 = 1'b1; cmd0 = 16'h1111; wrt1 = 1'b1; cmd1 = 16'h2222;
        tick(1);
        wrt0 = 1'b0; wrt1 = 1'b0;
        chk("both busy", {busy0, busy1}, 2'b11);
        wait_sig(0, 50, "sim done0", t_a);
        wait_sig(1, 50, "sim done1", t_b);
        chk("done0 to m_wrt1 spacing", t_mwrt - t_a, GAP_CYC + 1);
        tick(GAP_CYC + 3);

        // Single request with latency check
        q_mwrt.push_back(16'hA400);
        q_done0.push_back(16'h00C3);
        t_iss = cyc;
        issue(0, 16'hA400);
        chk("busy0 after accept", busy0, 1);
        wait_sig(0, 50, "single done0", t_a);
        chk("m_wrt latency", t_mwrt - t_iss, 2);
        chk("rd_data0 single", rd_data0, 16'h00C3);
        chk("busy0 in done cycle", busy0, 0);
        tick(GAP_CYC + 3);

        // Simultaneous repeat: requester 1 wins after requester 0 was last
        q_mwrt.push_back(16'h4444); q_mwrt.push_back(16'h3333);
        q_done1.push_back(16'hBBBB); q_done0.push_back(16'hCCCC);
        wrt0 = 1'b1; cmd0 = 16'h3333; wrt1 = 1'b1; cmd1 = 16'h4444;
        tick(1);
        wrt0 = 1'b0; wrt1 = 1'b0;
        wait_sig(1, 50, "repeat done1", t_a);
        wait_sig(0, 50, "repeat done0", t_b);
        chk("repeat order", t_b > t_a, 1);
        tick(GAP_CYC + 3);

        // Overrun on requester 1 while its transaction is in WAIT
        mst_lat = 6;
        q_mwrt.push_back(16'h5555);
        q_done1.push_back(16'hAAAA);
        issue(1, 16'h5555);
        tick(2);
        q_ovr1.push_back(1'b1);
        issue(1, 16'h1234);
        chk("m_cmd held after overrun", m_cmd, 16'h5555);
        chk("busy1 during overrun", busy1, 1);
        wait_sig(1, 50, "overrun done1", t_a);
        chk("rd_data1 after overrun", rd_data1, 16'hAAAA);
        tick(GAP_CYC + 3);

        // Timeout: reply arrives one cycle too late (lands in GAP, ignored)
        mst_lat = TMO_CYC + 1;
        q_mwrt.push_back(16'h6666);
        q_tmo0.push_back(16'hCCCC);
        issue(0, 16'h6666);
        wait_sig(2, TMO_CYC + 20, "tmo0", t_a);
        chk("timeout cycle", t_a - t_mwrt, TMO_CYC + 1);
        chk("rd_data0 unchanged on tmo", rd_data0, 16'hCCCC);
        chk("busy0 in tmo cycle", busy0, 0);
        tick(GAP_CYC + 3);

        // m_done exactly on the terminal count counts as completion
        mst_lat = TMO_CYC;
        q_mwrt.push_back(16'h0F0F);
        q_done0.push_back(16'hF0F0);
        issue(0, 16'h0F0F);
        wait_sig(0, TMO_CYC + 20, "terminal done0", t_a);
        chk("terminal done cycle", t_a - t_mwrt, TMO_CYC + 1);
        tick(GAP_CYC + 3);

        // Back-to-back: new wrt0 in the done0 cycle is accepted
        mst_lat = 2;
        q_mwrt.push_back(16'h7777);
        q_done0.push_back(16'h8888);
        issue(0, 16'h7777);
        wait_sig(0, 50, "b2b first done0", t_a);
        q_mwrt.push_back(16'h9999);
        q_done0.push_back(16'h6666);
        issue(0, 16'h9999);
        chk("busy0 after b2b accept", busy0, 1);
        wait_sig(0, 50, "b2b second done0", t_b);
        chk("rd_data0 b2b", rd_data0, 16'h6666);
        tick(GAP_CYC + 3);

        // Mid-transaction reset, then a stray m_done
        mst_en = 1'b0;
        q_mwrt.push_back(16'hABCD);
        issue(1, 16'hABCD);
        tick(3);
        chk("busy1 before reset", busy1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {busy0, busy1, done0, done1, tmo0, tmo1, ovr0, ovr1,
                                    m_wrt, m_cmd, rd_data0, rd_data1}, 64'h0);
        tick(2);
        rst_n = 1'b1;
        n_before = n_done1;
        stray_req++;
        tick(10);
        chk("no done1 from stray m_done", n_done1, n_before);
        chk("idle after reset", {busy0, busy1, rd_data1}, 18'h0);

        // Every expected event must have been consumed
        chk("q_mwrt empty",  q_mwrt.size(),  0);
        chk("q_done0 empty", q_done0.size(), 0);
        chk("q_done1 empty", q_done1.size(), 0);
        chk("q_tmo0 empty",  q_tmo0.size(),  0);
        chk("q_tmo1 empty",  q_tmo1.size(),  0);
        chk("q_ovr0 empty",  q_ovr0.size(),  0);
        chk("q_ovr1 empty",  q_ovr1.size(),  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
